// File: rtl/ieee_fp_seq_multiplier_if.sv
// Handshake bus for ieee_fp_seq_multiplier: operand channel (in_valid/in_ready,
// a, b) and result channel (out_valid/out_ready, result, flags).
interface ieee_fp_seq_multiplier_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [2:0]   flags;

    // Producer/consumer side of the multiplier
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    // The multiplier itself
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/ieee_fp_seq_multiplier.sv
// Multi-cycle IEEE-754 multiplier: radix-2 shift-add significand product,
// single-cycle normalise/round, DAZ on inputs and flush-to-zero on outputs.
// Optional macro IEEE_MUL_RNE_EN selects round-to-nearest-even; without it
// the result is truncated (round toward zero). Latency is the same in both.
module ieee_fp_seq_multiplier #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic                     clk,
    input logic                     rst_n,
    ieee_fp_seq_multiplier_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int PW = 2 * N;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(N);

    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                 state, state_n;
    logic                   sign_r;
    logic signed [EW-1:0]   exp_r;
    logic [PW-1:0]          acc;
    logic [PW-1:0]          mcand;
    logic [N-1:0]           mplier;
    logic [CW-1:0]          cnt;
    logic [W-1:0]           res_r;
    logic [2:0]             flags_r;

    logic                   sa, sb;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                   spec_hit;
    logic [W-1:0]           spec_res;
    logic [2:0]             spec_flags;

    logic [PW-2:0]          sh;
    logic [MAN_W-1:0]       frac_t;
    logic [MAN_W-1:0]       frac_rnd;
    logic                   guard, sticky, inc, carry;
    logic signed [EW-1:0]   exp_f;
    logic [W-1:0]           norm_res;
    logic [2:0]             norm_flags;

    assign {sa, ea, fa} = bus.a;
    assign {sb, eb, fb} = bus.b;

    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_nan  = (&ea) &  (|fa);
    assign b_nan  = (&eb) &  (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);

    // Special-operand classification (subnormals already count as zero)
    always_comb begin
        spec_hit   = 1'b0;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_hit   = 1'b1;
            spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_flags = 3'b100;
        end else if (a_inf || b_inf) begin
            spec_hit = 1'b1;
            spec_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_hit = 1'b1;
            spec_res = {sa ^ sb, {(W-1){1'b0}}};
        end
    end

    // Normalise the product: the leading one is dropped, leaving fraction,
    // guard and sticky in fixed positions
    always_comb begin
        sh     = acc[PW-1] ? acc[PW-2:0] : {acc[PW-3:0], 1'b0};
        frac_t = sh[PW-2 -: MAN_W];
        guard  = sh[N-1];
        sticky = |sh[N-2:0];
    end

`ifdef IEEE_MUL_RNE_EN
    assign inc = guard & (sticky | frac_t[0]);
`else
    logic unused_round;
    assign inc          = 1'b0;
    assign unused_round = guard ^ sticky;
`endif

    // Round, apply exponent adjustments and range checks
    always_comb begin
        {carry, frac_rnd} = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
        exp_f      = exp_r + {{(EW-1){1'b0}}, acc[PW-1]} + {{(EW-1){1'b0}}, carry};
        norm_res   = {sign_r, exp_f[EXP_W-1:0], frac_rnd};
        norm_flags = '0;
        if (exp_f >= EMAX) begin
            norm_res   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_flags = 3'b010;
        end else if (exp_f <= EZERO) begin
            norm_res   = {sign_r, {(W-1){1'b0}}};
            norm_flags = 3'b001;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n       = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_n = spec_hit ? DONE : MUL;
            end
            MUL:  if (cnt == CW'(N - 1)) state_n = NORM;
            NORM: state_n = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iterations and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r  <= 1'b0;
            exp_r   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            res_r   <= '0;
            flags_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign_r <= sa ^ sb;
                    if (spec_hit) begin
                        res_r   <= spec_res;
                        flags_r <= spec_flags;
                    end else begin
                        mcand  <= PW'({1'b1, fa});
                        mplier <= {1'b1, fb};
                        acc    <= '0;
                        cnt    <= '0;
                        exp_r  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                NORM: begin
                    res_r   <= norm_res;
                    flags_r <= norm_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = res_r;
    assign bus.flags  = flags_r;
endmodule

// File: tb/tb_ieee_fp_seq_multiplier.sv
// Self-checking bench for ieee_fp_seq_multiplier (binary32). Expected
// results are queued when operands are driven and popped on out_valid.
module tb_ieee_fp_seq_multiplier;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    ieee_fp_seq_multiplier_if #(.EXP_W(8), .MAN_W(23)) bus ();

    ieee_fp_seq_multiplier #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drive one operand pair for a single accept edge and queue its expectation
    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] r, input logic [2:0] f, input int l);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        exp_q.push_back('{res: r, flg: f, lat: l});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges, accept edge included, until out_valid (bounded)
    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready act=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid act=%b exp=0", bus.out_valid); end
        total++; if (bus.result !== 32'h0)   begin bad++; $display("FAIL reset_result act=%h exp=00000000", bus.result); end
        total++; if (bus.flags !== 3'b000)   begin bad++; $display("FAIL reset_flags act=%b exp=000", bus.flags); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_normal;
        exp_t e;
        int   lat;
        send(32'h40400000, 32'h40000000, 32'h40C00000, 3'b000, 26);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL normal_result act=%h exp=%h", bus.result, e.res); end
        total++; if (bus.flags !== e.flg)  begin bad++; $display("FAIL normal_flags act=%b exp=%b", bus.flags, e.flg); end
        total++; if (lat !== e.lat)        begin bad++; $display("FAIL normal_latency act=%0d exp=%0d", lat, e.lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        exp_t        e;
        int          lat;
        logic [31:0] held;
        bus.out_ready = 1'b0;
        send(32'h3FC00000, 32'hBFC00000, 32'hC0100000, 3'b000, 26);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL bp_result act=%h exp=%h", bus.result, e.res); end
        total++; if (lat !== e.lat)        begin bad++; $display("FAIL bp_latency act=%0d exp=%0d", lat, e.lat); end
        held = e.res;
        // new operands offered during the stall must be ignored
        bus.a        = 32'h40400000;
        bus.b        = 32'h40400000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (bus.result !== held)    begin bad++; $display("FAIL bp_hold_result cyc=%0d act=%h exp=%h", i, bus.result, held); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d act=%b exp=1", i, bus.out_valid); end
            total++; if (bus.in_ready !== 1'b0)  begin bad++; $display("FAIL bp_in_ready cyc=%0d act=%b exp=0", i, bus.in_ready); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid act=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_ready act=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_special;
        exp_t e;
        int   lat;
        send(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 1);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL inf_x_zero_result act=%h exp=%h", bus.result, e.res); end
        total++; if (bus.flags !== e.flg)  begin bad++; $display("FAIL inf_x_zero_flags act=%b exp=%b", bus.flags, e.flg); end
        total++; if (lat !== e.lat)        begin bad++; $display("FAIL inf_x_zero_latency act=%0d exp=%0d", lat, e.lat); end
        @(posedge clk); #1;
        send(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL neg_inf_result act=%h exp=%h", bus.result, e.res); end
        total++; if (bus.flags !== e.flg)  begin bad++; $display("FAIL neg_inf_flags act=%b exp=%b", bus.flags, e.flg); end
        total++; if (lat !== e.lat)        begin bad++; $display("FAIL neg_inf_latency act=%0d exp=%0d", lat, e.lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_range;
        exp_t        e;
        int          lat;
        logic [31:0] ops_a [3];
        logic [31:0] ops_b [3];
        logic [31:0] rs    [3];
        logic [2:0]  fs    [3];
        int          ls    [3];
        ops_a = '{32'h7F000000, 32'h00800000, 32'h00000001};
        ops_b = '{32'h7F000000, 32'h00800000, 32'h3F800000};
        rs    = '{32'h7F800000, 32'h00000000, 32'h00000000};
        fs    = '{3'b010, 3'b001, 3'b000};
        ls    = '{26, 26, 1};
        for (int i = 0; i < 3; i++) begin
            send(ops_a[i], ops_b[i], rs[i], fs[i], ls[i]);
            wait_valid(lat);
            e = exp_q.pop_front();
            total++; if (bus.result !== e.res) begin bad++; $display("FAIL range_result case=%0d act=%h exp=%h", i, bus.result, e.res); end
            total++; if (bus.flags !== e.flg)  begin bad++; $display("FAIL range_flags case=%0d act=%b exp=%b", i, bus.flags, e.flg); end
            total++; if (lat !== e.lat)        begin bad++; $display("FAIL range_latency case=%0d act=%0d exp=%0d", i, lat, e.lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rounding;
        exp_t        e;
        int          lat;
        logic [31:0] r;
`ifdef IEEE_MUL_RNE_EN
        r = 32'h40100002;
`else
        r = 32'h40100001;
`endif
        send(32'h3FC00001, 32'h3FC00001, r, 3'b000, 26);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL round_result act=%h exp=%h", bus.result, e.res); end
        total++; if (bus.flags !== e.flg)  begin bad++; $display("FAIL round_flags act=%b exp=%b", bus.flags, e.flg); end
        total++; if (lat !== e.lat)        begin bad++; $display("FAIL round_latency act=%0d exp=%0d", lat, e.lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop;
        exp_t e;
        int   lat;
        bus.a        = 32'h40400000;
        bus.b        = 32'h40400000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midop_out_valid act=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL midop_in_ready act=%b exp=1", bus.in_ready); end
        @(posedge clk); #1;
        total++; if (bus.result !== 32'h0)   begin bad++; $display("FAIL midop_result act=%h exp=00000000", bus.result); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 26);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL after_reset_result act=%h exp=%h", bus.result, e.res); end
        total++; if (bus.flags !== e.flg)  begin bad++; $display("FAIL after_reset_flags act=%b exp=%b", bus.flags, e.flg); end
        total++; if (lat !== e.lat)        begin bad++; $display("FAIL after_reset_latency act=%0d exp=%0d", lat, e.lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   lat;
        bus.out_ready = 1'b1;
        bus.a         = 32'h40000000;
        bus.b         = 32'h40000000;
        bus.in_valid  = 1'b1;
        exp_q.push_back('{res: 32'h40800000, flg: 3'b000, lat: 26});
        @(posedge clk); #1;
        // second operands offered while busy; in_valid stays high throughout
        bus.a = 32'h7FC00001;
        bus.b = 32'h3F800000;
        exp_q.push_back('{res: 32'h7FC00000, flg: 3'b100, lat: 1});
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL b2b_first_result act=%h exp=%h", bus.result, e.res); end
        total++; if (lat !== e.lat)        begin bad++; $display("FAIL b2b_first_latency act=%0d exp=%0d", lat, e.lat); end
        @(posedge clk); #1;
        total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL b2b_gap_in_ready act=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap_out_valid act=%b exp=0", bus.out_valid); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        e = exp_q.pop_front();
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL b2b_second_result act=%h exp=%h", bus.result, e.res); end
        total++; if (bus.flags !== e.flg)  begin bad++; $display("FAIL b2b_second_flags act=%b exp=%b", bus.flags, e.flg); end
        total++; if (lat !== e.lat)        begin bad++; $display("FAIL b2b_second_latency act=%0d exp=%0d", lat, e.lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_normal();
        test_backpressure();
        test_special();
        test_range();
        test_rounding();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
